// File: rtl/fetch_to_decode_tx.sv
// Transmit-side endpoint of the fetch-to-decode bus: a DEPTH-entry FIFO feeding a bus holding register.
// Define FETCH_DECODE_TX_BYPASS_EN to let a packet skip the empty FIFO straight onto the bus.
module fetch_to_decode_tx #(
  parameter int PKT_W = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fetch_valid,
  input  logic [PKT_W-1:0]               fetch_pkt,
  output logic                           fetch_ready,
  input  logic                           flush,
  output logic                           bus_is_busy,
  output logic [PKT_W-1:0]               bus_data,
  input  logic                           bus_recv,
  output logic [$clog2(DEPTH+2)-1:0]     occupancy,
  output logic                           proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(DEPTH + 2);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PKT_W-1:0] r_bus_data;
  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_proto_err;

  logic w_busy;
  logic w_fifo_empty;
  logic w_accept;
  logic w_recv;
  logic w_bus_free;
  logic w_pop;
  logic w_byp;
  logic w_push;

  assign w_busy       = (r_state == S_BUSY);
  assign w_fifo_empty = (r_count == '0);
  assign fetch_ready  = (r_count < CW'(DEPTH));

  // Flush masks every other request in its cycle, including the protocol check.
  assign w_accept   = fetch_valid && fetch_ready && !flush;
  assign w_recv     = bus_recv && w_busy && !flush;
  assign w_bus_free = !flush && (!w_busy || w_recv);
  assign w_pop      = w_bus_free && !w_fifo_empty;

`ifdef FETCH_DECODE_TX_BYPASS_EN
  assign w_byp = w_bus_free && w_fifo_empty && w_accept;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = w_accept && !w_byp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else if (w_pop || w_byp) begin
      w_state_next = S_BUSY;
    end else if (w_recv) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_data <= '0;
    end else if (w_pop) begin
      r_bus_data <= r_mem[r_rd_ptr];
    end else if (w_byp) begin
      r_bus_data <= fetch_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= fetch_pkt;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (bus_recv && !w_busy && !flush) begin
      r_proto_err <= 1'b1;
    end
  end

  assign bus_is_busy = w_busy;
  assign bus_data    = r_bus_data;
  assign proto_err   = r_proto_err;
  assign occupancy   = OW'(r_count) + OW'(w_busy);

endmodule

// File: tb/tb_fetch_to_decode_tx.sv
// Self-checking bench for fetch_to_decode_tx: directed scenarios plus random traffic
// checked against a queue-level model of the packets held by the endpoint.
module tb_fetch_to_decode_tx;

  localparam int PKT_W = 64;
  localparam int DEPTH = 4;
`ifdef FETCH_DECODE_TX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fetch_valid = 1'b0;
  logic [PKT_W-1:0] fetch_pkt = '0;
  logic             fetch_ready;
  logic             flush = 1'b0;
  logic             bus_is_busy;
  logic [PKT_W-1:0] bus_data;
  logic             bus_recv = 1'b0;
  logic [2:0]       occupancy;
  logic             proto_err;

  int tests = 0;
  int fails = 0;

  logic [PKT_W-1:0] q[$];
  bit               m_onbus;
  bit               m_err;

  fetch_to_decode_tx #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_pkt   (fetch_pkt),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .bus_is_busy (bus_is_busy),
    .bus_data    (bus_data),
    .bus_recv    (bus_recv),
    .occupancy   (occupancy),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // Model: q holds every accepted, unconsumed packet in order; m_onbus says whether q[0] is on the bus.
  function automatic bit model_ready();
    return (q.size() - int'(m_onbus)) < DEPTH;
  endfunction

  function automatic void model_update(input logic fv, input logic [PKT_W-1:0] pkt,
                                       input logic rc, input logic fl);
    int  fifo_cnt;
    bit  acc;
    bit  recv_ok;
    bit  free;
    fifo_cnt = q.size() - int'(m_onbus);
    if (fl) begin
      q.delete();
      m_onbus = 1'b0;
    end else begin
      acc     = fv && (fifo_cnt < DEPTH);
      recv_ok = rc && m_onbus;
      if (rc && !m_onbus) m_err = 1'b1;
      if (recv_ok) void'(q.pop_front());
      free = !m_onbus || recv_ok;
      if (acc) q.push_back(pkt);
      if (BYP) m_onbus = (q.size() > 0);
      else     m_onbus = (m_onbus && !recv_ok) || (free && fifo_cnt > 0);
    end
  endfunction

  task automatic step(input logic fv, input logic [PKT_W-1:0] pkt, input logic rc, input logic fl);
    fetch_valid = fv;
    fetch_pkt   = pkt;
    bus_recv    = rc;
    flush       = fl;
    @(posedge clk);
    #1;
    model_update(fv, pkt, rc, fl);
    fetch_valid = 1'b0;
    bus_recv    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic reset_dut();
    fetch_valid = 1'b0;
    bus_recv    = 1'b0;
    flush       = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_onbus = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    tests++; if (bus_is_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_is_busy); end
    tests++; if (bus_data !== '0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", bus_data); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", proto_err); end
    tests++; if (fetch_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", fetch_ready); end
  endtask

  task automatic test_single();
    reset_dut();
    step(1'b1, 64'h1111, 1'b0, 1'b0);
    tests++; if (bus_is_busy !== BYP) begin fails++; $display("[TB] FAIL single_latency1: busy %b expected %b", bus_is_busy, BYP); end
    if (!BYP) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tests++; if (bus_is_busy !== 1'b1 || bus_data !== 64'h1111) begin
        fails++; $display("[TB] FAIL single_hold cycle %0d: busy %b data %h expected 1 1111", i, bus_is_busy, bus_data);
      end
      tests++; if (occupancy !== 3'd1) begin fails++; $display("[TB] FAIL single_occ cycle %0d: got %0d expected 1", i, occupancy); end
      step(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fill();
    reset_dut();
    for (int i = 1; i <= 5; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
    tests++; if (fetch_ready !== 1'b0) begin fails++; $display("[TB] FAIL fill_ready: got %b expected 0", fetch_ready); end
    tests++; if (occupancy !== 3'd5) begin fails++; $display("[TB] FAIL fill_occ: got %0d expected 5", occupancy); end
    step(1'b1, 64'd6, 1'b0, 1'b0);
    tests++; if (occupancy !== 3'd5) begin fails++; $display("[TB] FAIL fill_sixth: occ %0d expected 5", occupancy); end
    for (int i = 1; i <= 5; i++) begin
      tests++; if (bus_is_busy !== 1'b1 || bus_data !== 64'(i)) begin
        fails++; $display("[TB] FAIL fill_order %0d: busy %b data %h expected 1 %h", i, bus_is_busy, bus_data, 64'(i));
      end
      step(1'b0, '0, 1'b1, 1'b0);
      if (i == 1) begin
        tests++; if (fetch_ready !== 1'b1) begin fails++; $display("[TB] FAIL fill_ready_after_pop: got %b expected 1", fetch_ready); end
      end
    end
    tests++; if (bus_is_busy !== 1'b0 || occupancy !== 3'd0) begin
      fails++; $display("[TB] FAIL fill_drained: busy %b occ %0d expected 0 0", bus_is_busy, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    int nextExp = 0;
    reset_dut();
    for (int c = 0; c < 100; c++) begin
      step(1'b1, 64'(c), 1'b1, 1'b0);
      tests++; if (occupancy > 3'd2) begin fails++; $display("[TB] FAIL stream_occ cycle %0d: got %0d expected <=2", c, occupancy); end
      if (c >= 2) begin
        tests++; if (bus_is_busy !== 1'b1) begin fails++; $display("[TB] FAIL stream_gap cycle %0d: busy %b expected 1", c, bus_is_busy); end
      end
      if (bus_is_busy === 1'b1) begin
        tests++; if (bus_data !== 64'(nextExp)) begin fails++; $display("[TB] FAIL stream_order cycle %0d: got %h expected %h", c, bus_data, 64'(nextExp)); end
        nextExp++;
      end
    end
    tests++; if (nextExp != (BYP ? 100 : 99)) begin fails++; $display("[TB] FAIL stream_count: got %0d expected %0d", nextExp, BYP ? 100 : 99); end
  endtask

  task automatic test_flush();
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'hAA, 1'b1, 1'b1);
    tests++; if (bus_is_busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_busy: got %b expected 0", bus_is_busy); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("[TB] FAIL flush_occ: got %0d expected 0", occupancy); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("[TB] FAIL flush_err: got %b expected 0", proto_err); end
    tests++; if (fetch_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_ready: got %b expected 1", fetch_ready); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      tests++; if (bus_is_busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_leak cycle %0d: busy %b data %h expected idle", i, bus_is_busy, bus_data); end
    end
  endtask

  task automatic test_proto_err();
    reset_dut();
    step(1'b0, '0, 1'b1, 1'b0);
    tests++; if (proto_err !== 1'b1) begin fails++; $display("[TB] FAIL perr_set: got %b expected 1", proto_err); end
    step(1'b0, '0, 1'b0, 1'b1);
    tests++; if (proto_err !== 1'b1) begin fails++; $display("[TB] FAIL perr_flush: got %b expected 1", proto_err); end
    reset_dut();
    tests++; if (proto_err !== 1'b0) begin fails++; $display("[TB] FAIL perr_reset: got %b expected 0", proto_err); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int i = 0; i < 4; i++) step(1'b1, 64'h40 + 64'(i), 1'b0, 1'b0);
    tests++; if (occupancy !== 3'd4) begin fails++; $display("[TB] FAIL areset_pre_occ: got %0d expected 4", occupancy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus_is_busy !== 1'b0 || bus_data !== '0) begin
      fails++; $display("[TB] FAIL areset_bus: busy %b data %h expected 0 0", bus_is_busy, bus_data);
    end
    tests++; if (occupancy !== 3'd0 || fetch_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL areset_fifo: occ %0d ready %b expected 0 1", occupancy, fetch_ready);
    end
    #1 rst_n = 1'b1;
    q.delete();
    m_onbus = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic test_random();
    logic fv;
    logic rc;
    logic fl;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      fv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 49) == 0);
      step(fv, {$urandom, $urandom}, rc, fl);
      tests++; if (bus_is_busy !== m_onbus) begin fails++; $display("[TB] FAIL rand_busy cycle %0d: got %b expected %b", c, bus_is_busy, m_onbus); end
      if (m_onbus) begin
        tests++; if (bus_data !== q[0]) begin fails++; $display("[TB] FAIL rand_data cycle %0d: got %h expected %h", c, bus_data, q[0]); end
      end
      tests++; if (int'(occupancy) != q.size()) begin fails++; $display("[TB] FAIL rand_occ cycle %0d: got %0d expected %0d", c, occupancy, q.size()); end
      tests++; if (fetch_ready !== model_ready()) begin fails++; $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", c, fetch_ready, model_ready()); end
      tests++; if (proto_err !== m_err) begin fails++; $display("[TB] FAIL rand_err cycle %0d: got %b expected %b", c, proto_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
